// File: rtl/fp_div_param.sv
// fp_div_param: parametrised IEEE-754 divider z = a / b.
// Iterative restoring quotient core retiring BITS_PER_CYCLE bits per clock,
// round-to-nearest-even, subnormals flushed to zero, full special-case handling.
// Optional exception flags output enabled by defining FP_DIV_FLAGS_EN.
module fp_div_param #(
  parameter int EXP_W          = 11,
  parameter int MAN_W          = 52,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] i_a,
  input  logic [EXP_W+MAN_W:0] i_b,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [EXP_W+MAN_W:0] o_z
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic [4:0]           o_flags
`endif
);

  localparam int W     = EXP_W + MAN_W + 1;
  localparam int Q_W   = MAN_W + 3;
  localparam int ITERS = (Q_W + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int QB    = ITERS * BITS_PER_CYCLE;
  localparam int R_W   = MAN_W + 2;
  localparam int E_W   = EXP_W + 2;
  localparam int CNT_W = $clog2(ITERS + 1);

  localparam logic signed [E_W-1:0] BIAS     = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] EXP_MAX  = E_W'((1 << EXP_W) - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic [W-1:0]          QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;

  // Round to nearest, ties to even, on {hidden, mantissa}; result keeps the carry bit.
  function automatic logic [MAN_W+1:0] round_rne(input logic [MAN_W:0] keep,
                                                 input logic guard,
                                                 input logic sticky);
    logic inc;
    inc = guard & (sticky | keep[0]);
    return {1'b0, keep} + {{(MAN_W+1){1'b0}}, inc};
  endfunction

  // Classify the final exponent: {overflow, underflow}.
  function automatic logic [1:0] exp_range(input logic signed [E_W-1:0] e);
    logic ovf;
    logic unf;
    ovf = !e[E_W-1] && (e >= EXP_MAX);
    unf = e[E_W-1] || (e == BIAS - BIAS);
    return {ovf, unf};
  endfunction

  // Saturate out-of-range exponents to signed infinity / signed zero.
  function automatic logic [W-1:0] sat_pack(input logic s,
                                            input logic [1:0] rng,
                                            input logic [EXP_W-1:0] e,
                                            input logic [MAN_W-1:0] m);
    if (rng[1]) return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    if (rng[0]) return {s, {(W-1){1'b0}}};
    return {s, e, m};
  endfunction

  state_t state, state_nxt;

  logic [W-1:0]             a_q, b_q;
  logic                     a_sgn, b_sgn;
  logic [EXP_W-1:0]         a_exp, b_exp;
  logic [MAN_W-1:0]         a_man, b_man;
  logic                     a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic                     res_sgn;
  logic                     sp_invalid, sp_inf, sp_zero, special;
  logic [W-1:0]             spec_z;

  logic                     res_sgn_q;
  logic signed [E_W-1:0]    exp_q;
  logic [MAN_W:0]           div_q;
  logic [R_W-1:0]           rem_q, rem_nxt;
  logic [QB-1:0]            quo_q, quo_nxt;
  logic [CNT_W-1:0]         cnt_q;

  logic                     norm;
  logic [QB-1:0]            q_n, q_low;
  logic                     guard, sticky, carry;
  logic [MAN_W+1:0]         rnd_sum;
  logic signed [E_W-1:0]    e_adj, e_fin;
  logic [1:0]               rng;
  logic [W-1:0]             round_z;

  assign a_sgn = a_q[W-1];
  assign b_sgn = b_q[W-1];
  assign a_exp = a_q[W-2 -: EXP_W];
  assign b_exp = b_q[W-2 -: EXP_W];
  assign a_man = a_q[MAN_W-1:0];
  assign b_man = b_q[MAN_W-1:0];

  // Operand classification and special-case result selection
  always_comb begin
    a_zero     = (a_exp == '0);
    b_zero     = (b_exp == '0);
    a_inf      = (a_exp == '1) && (a_man == '0);
    b_inf      = (b_exp == '1) && (b_man == '0);
    a_nan      = (a_exp == '1) && (a_man != '0);
    b_nan      = (b_exp == '1) && (b_man != '0);
    res_sgn    = a_sgn ^ b_sgn;
    sp_invalid = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    sp_inf     = !sp_invalid & (a_inf | b_zero);
    sp_zero    = !sp_invalid & !sp_inf & (a_zero | b_inf);
    special    = sp_invalid | sp_inf | sp_zero;
    if (sp_invalid)  spec_z = QNAN;
    else if (sp_inf) spec_z = {res_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else             spec_z = {res_sgn, {(W-1){1'b0}}};
  end

  // DIVIDE stage: BITS_PER_CYCLE restoring radix-2 steps per clock
  always_comb begin
    rem_nxt = rem_q;
    quo_nxt = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (rem_nxt >= {1'b0, div_q}) begin
        rem_nxt = rem_nxt - {1'b0, div_q};
        quo_nxt = {quo_nxt[QB-2:0], 1'b1};
      end else begin
        quo_nxt = {quo_nxt[QB-2:0], 1'b0};
      end
      rem_nxt = rem_nxt << 1;
    end
  end

  // ROUND stage: normalise, round, adjust exponent and saturate
  always_comb begin
    norm    = quo_q[QB-1];
    q_n     = norm ? quo_q : (quo_q << 1);
    guard   = q_n[QB-MAN_W-2];
    q_low   = q_n << (MAN_W + 2);
    sticky  = (q_low != '0) | (rem_q != '0);
    rnd_sum = round_rne(q_n[QB-1 -: MAN_W+1], guard, sticky);
    // the rounded significand is either 01.f or exactly 10.0
    carry   = rnd_sum[MAN_W+1] & !rnd_sum[MAN_W];
    e_adj   = {{(E_W-1){1'b0}}, carry} - {{(E_W-1){1'b0}}, !norm};
    e_fin   = exp_q + e_adj;
    rng     = exp_range(e_fin);
    round_z = sat_pack(res_sgn_q, rng, e_fin[EXP_W-1:0], rnd_sum[MAN_W-1:0]);
  end

  // Control state register and iteration counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == UNPACK)      cnt_q <= '0;
      else if (state == DIVIDE) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (start) state_nxt = UNPACK;
      end
      UNPACK:  state_nxt = special ? DONE : DIVIDE;
      DIVIDE:  if (cnt_q == CNT_LAST) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE: begin
        o_valid   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: operand capture, unpack, quotient iteration
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          a_q <= i_a;
          b_q <= i_b;
        end
      end
      UNPACK: begin
        res_sgn_q <= res_sgn;
        exp_q     <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS;
        div_q     <= {1'b1, b_man};
        // partial remainder starts as the dividend so the first step yields the integer bit
        rem_q     <= {2'b01, a_man};
        quo_q     <= '0;
      end
      DIVIDE: begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
      end
      default: ;
    endcase
  end

  // Result register, loaded on entry to DONE and held until the next result
  always_ff @(posedge clk) begin
    if (!reset)                          o_z <= '0;
    else if (state == UNPACK && special) o_z <= spec_z;
    else if (state == ROUND)             o_z <= round_z;
  end

`ifdef FP_DIV_FLAGS_EN
  logic       sp_divzero;
  logic [4:0] spec_flags, round_flags;

  assign sp_divzero  = !sp_invalid & !a_inf & b_zero;
  assign spec_flags  = {sp_invalid, sp_divzero, 3'b000};
  assign round_flags = {2'b00, rng, guard | sticky | rng[1] | rng[0]};

  // Exception flags, registered alongside the result
  always_ff @(posedge clk) begin
    if (!reset)                          o_flags <= '0;
    else if (state == UNPACK && special) o_flags <= spec_flags;
    else if (state == ROUND)             o_flags <= round_flags;
  end
`endif

endmodule

// File: tb/tb_fp_div_param.sv
// tb_fp_div_param: directed-vector bench for fp_div_param (double precision,
// plus a single-precision instance with 4 quotient bits per cycle).
module tb_fp_div_param;

  logic        clk;
  logic        reset;
  logic        start, s_start;
  logic [63:0] i_a, i_b, o_z;
  logic        o_ready, o_valid;
  logic [31:0] s_a, s_b, s_z;
  logic        s_ready, s_valid;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0]  flags, s_flags, last_flags;
`endif

  int total = 0;
  int bad   = 0;

  fp_div_param #(.EXP_W(11), .MAN_W(52), .BITS_PER_CYCLE(2)) u_dp (
    .clk(clk), .reset(reset), .start(start), .i_a(i_a), .i_b(i_b),
    .o_ready(o_ready), .o_valid(o_valid), .o_z(o_z)
`ifdef FP_DIV_FLAGS_EN
    , .o_flags(flags)
`endif
  );

  fp_div_param #(.EXP_W(8), .MAN_W(23), .BITS_PER_CYCLE(4)) u_sp (
    .clk(clk), .reset(reset), .start(s_start), .i_a(s_a), .i_b(s_b),
    .o_ready(s_ready), .o_valid(s_valid), .o_z(s_z)
`ifdef FP_DIV_FLAGS_EN
    , .o_flags(s_flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // One operation: start presented before an edge; edges counts from that edge.
  task automatic do_op(input bit sp, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] z, output int edges, output bit busy_ok);
    @(negedge clk);
    if (sp) begin s_a = a[31:0]; s_b = b[31:0]; s_start = 1'b1; end
    else    begin i_a = a;       i_b = b;       start   = 1'b1; end
    @(posedge clk);
    edges   = 1;
    busy_ok = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    s_start = 1'b0;
    while (!(sp ? s_valid : o_valid) && edges < 200) begin
      if (sp ? s_ready : o_ready) busy_ok = 1'b0;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    z = sp ? {32'h0, s_z} : o_z;
`ifdef FP_DIV_FLAGS_EN
    last_flags = sp ? s_flags : flags;
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] z;
    int          n;
    bit          bok;
    int          vc;

    clk = 1'b0; reset = 1'b0; start = 1'b0; s_start = 1'b0;
    i_a = '0; i_b = '0; s_a = '0; s_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_z",     o_z,          64'h0);
`ifdef FP_DIV_FLAGS_EN
    chk("rst_flags", 64'(flags),   64'h0);
`endif
    reset = 1'b1;

    // 6.0 / 2.0
    do_op(1'b0, 64'h4018000000000000, 64'h4000000000000000, z, n, bok);
    chk("div62_lat",  64'(n),   64'd31);
    chk("div62_z",    z,        64'h4008000000000000);
    chk("div62_busy", 64'(bok), 64'd1);
`ifdef FP_DIV_FLAGS_EN
    chk("div62_flags", 64'(last_flags), 64'h0);
`endif
    @(negedge clk);
    chk("pulse_valid", 64'(o_valid), 64'd0);
    chk("pulse_ready", 64'(o_ready), 64'd1);
    chk("hold_z",      o_z,          64'h4008000000000000);

    // 1.0 / 3.0
    do_op(1'b0, 64'h3FF0000000000000, 64'h4008000000000000, z, n, bok);
    chk("div13_z", z, 64'h3FD5555555555555);
`ifdef FP_DIV_FLAGS_EN
    chk("div13_flags", 64'(last_flags), 64'h01);
`endif

    // single precision, 4 bits/cycle: latency ITERS(7)+2 after the sampling edge
    do_op(1'b1, 64'h3F800000, 64'h40400000, z, n, bok);
    chk("sp13_lat", 64'(n), 64'd10);
    chk("sp13_z",   z,      64'h3EAAAAAB);
    do_op(1'b1, 64'h40C00000, 64'h40000000, z, n, bok);
    chk("sp62_z",   z,      64'h40400000);

    // special cases
    do_op(1'b0, 64'h3FF0000000000000, 64'h0000000000000000, z, n, bok);
    chk("div10_lat", 64'(n), 64'd2);
    chk("div10_z",   z,      64'h7FF0000000000000);
`ifdef FP_DIV_FLAGS_EN
    chk("div10_flags", 64'(last_flags), 64'h08);
`endif
    do_op(1'b0, 64'h0000000000000000, 64'h0000000000000000, z, n, bok);
    chk("div00_lat", 64'(n), 64'd2);
    chk("div00_z",   z,      64'h7FF8000000000000);
`ifdef FP_DIV_FLAGS_EN
    chk("div00_flags", 64'(last_flags), 64'h10);
`endif
    do_op(1'b0, 64'hC000000000000000, 64'h7FF0000000000000, z, n, bok);
    chk("divm2inf_lat", 64'(n), 64'd2);
    chk("divm2inf_z",   z,      64'h8000000000000000);
    do_op(1'b0, 64'hFFF8000000000001, 64'h3FF0000000000000, z, n, bok);
    chk("nan_z", z, 64'h7FF8000000000000);
    do_op(1'b0, 64'h7FF0000000000000, 64'hFFF0000000000000, z, n, bok);
    chk("infinf_z", z, 64'h7FF8000000000000);
    do_op(1'b0, 64'hFFF0000000000000, 64'h4000000000000000, z, n, bok);
    chk("infx_z", z, 64'hFFF0000000000000);

    // exponent overflow and underflow
    do_op(1'b0, 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, z, n, bok);
    chk("ovf_z", z, 64'h7FF0000000000000);
`ifdef FP_DIV_FLAGS_EN
    chk("ovf_flags", 64'(last_flags), 64'h05);
`endif
    do_op(1'b0, 64'h0010000000000000, 64'h4000000000000000, z, n, bok);
    chk("unf_z", z, 64'h0000000000000000);
`ifdef FP_DIV_FLAGS_EN
    chk("unf_flags", 64'(last_flags), 64'h03);
`endif

    // start held high for the whole operation
    @(negedge clk);
    i_a = 64'h4018000000000000; i_b = 64'h4000000000000000; start = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    while (!o_valid && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("busy_lat", 64'(n), 64'd31);
    chk("busy_z",   o_z,    64'h4008000000000000);
    i_a = 64'h3FF0000000000000; i_b = 64'h0000000000000000;
    @(posedge clk);
    @(negedge clk);
    chk("busy_idle_ready", 64'(o_ready), 64'd1);
    chk("busy_idle_valid", 64'(o_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_accept", 64'(o_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("busy2_valid", 64'(o_valid), 64'd1);
    chk("busy2_z",     o_z,          64'h7FF0000000000000);

    // reset in the middle of DIVIDE
    @(negedge clk);
    i_a = 64'h4018000000000000; i_b = 64'h4000000000000000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ready", 64'(o_ready), 64'd1);
    chk("abort_valid", 64'(o_valid), 64'd0);
    chk("abort_z",     o_z,          64'h0);
    reset = 1'b1;
    vc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_valid) vc++;
    end
    chk("abort_no_stale", 64'(vc), 64'd0);
    do_op(1'b0, 64'h4018000000000000, 64'h4000000000000000, z, n, bok);
    chk("abort_redo_lat", 64'(n), 64'd31);
    chk("abort_redo_z",   z,      64'h4008000000000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
